mod_check_scheduler: RTL and testbench

Round-robin scheduler that shares a single serial divisibility engine among several requesters. Each requester presents a parallel word with a valid/ready handshake. The scheduler grants one requester, serializes the granted word MSB-first into a mod-DIVISOR residue FSM, and returns the divisible flag, the remainder and the requester id on a result handshake. It sits in front of the bit-serial divisibility datapath and sequences it for multi-client use.

---
 rtl/mod_check_scheduler_pkg.sv | 29 ++
 rtl/mod_check_scheduler_if.sv | 39 +++
 rtl/mod_check_scheduler_residue_step.sv | 27 ++
 rtl/mod_check_scheduler.sv | 137 +++++++++++++
 tb/tb_mod_check_scheduler.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_check_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mod_check_pkg
//  Brief    : Shared state encoding, default sizes and width helper for the
//             multi-client divisibility scheduler.
//  Revision : 1.0
// ============================================================================
package mod_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DIVISOR = 5;

    // Never returns 0 so that 1-entry ranges still get a legal 1-bit vector.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int ID_W  = clog2w(DEF_NUM_REQ);
    localparam int REM_W = clog2w(DEF_DIVISOR);

endpackage
`default_nettype wire

// File: rtl/mod_check_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : mod_check_scheduler_if
//  Brief    : Request / result handshake bundle of the divisibility scheduler.
//  Revision : 1.0
// ============================================================================
interface mod_check_scheduler_if
    import mod_check_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DIVISOR = DEF_DIVISOR
) ();

    localparam int c_ID_W  = clog2w(NUM_REQ);
    localparam int c_REM_W = clog2w(DIVISOR);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     res_valid;
    logic                     res_ready;
    logic [c_ID_W-1:0]        res_id;
    logic                     res_div;
    logic [c_REM_W-1:0]       res_rem;
    logic                     busy;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_div, res_rem, busy
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_div, res_rem, busy
    );

endinterface
`default_nettype wire

// File: rtl/mod_check_scheduler_residue_step.sv
`default_nettype none
// ============================================================================
//  Module   : mod_residue_step
//  Brief    : One MSB-first step of a mod-DIVISOR residue: (2*r + b) mod D.
//  Revision : 1.0
// ============================================================================
module mod_residue_step
    import mod_check_pkg::*;
#(
    parameter int  DIVISOR = DEF_DIVISOR,
    localparam int c_REM_W = clog2w(DIVISOR)
) (
    input  logic [c_REM_W-1:0] i_residue,
    input  logic               i_bit,
    output logic [c_REM_W-1:0] o_residue
);

    localparam logic [c_REM_W:0] c_DIV = (c_REM_W + 1)'(DIVISOR);

    logic [c_REM_W:0] w_sum;

    // 2*r+b never exceeds 2*D-1, so one conditional subtract is exact.
    assign w_sum     = {i_residue, i_bit};
    assign o_residue = (w_sum >= c_DIV) ? c_REM_W'(w_sum - c_DIV) : w_sum[c_REM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mod_check_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : mod_check_scheduler
//  Brief    : Round-robin front end sharing one bit-serial mod-DIVISOR engine.
//  Revision : 1.0
// ============================================================================
module mod_check_scheduler
    import mod_check_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DIVISOR = DEF_DIVISOR
) (
    input  logic                 clk,
    input  logic                 reset,
    mod_check_scheduler_if.slave bus
);

    localparam int c_ID_W  = clog2w(NUM_REQ);
    localparam int c_REM_W = clog2w(DIVISOR);
    localparam int c_CNT_W = clog2w(WIDTH);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_ID_W-1:0]  c_ID_LAST  = c_ID_W'(NUM_REQ - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_shift;
    logic [c_ID_W-1:0]    r_id;
    logic [c_ID_W-1:0]    r_last_grant;
    logic [c_ID_W-1:0]    w_winner;
    logic [c_ID_W-1:0]    w_cand;
    logic [c_REM_W-1:0]   r_residue;
    logic [c_REM_W-1:0]   w_residue_nxt;
    logic [c_REM_W-1:0]   r_res_rem;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_res_valid;
    logic                 r_res_div;
    logic                 w_any;
    logic                 w_accept;
    logic                 w_last_bit;
    logic [NUM_REQ-1:0]   w_req_ready;

    // Search order starts just past the previous winner.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_last_grant;
        w_cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = c_ID_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_any && bus.req_valid[w_cand]) begin
                w_any    = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Gated by reset so no requester sees an accept that the flops will drop.
    assign w_accept   = (r_state == IDLE) && w_any && reset;
    assign w_last_bit = (r_state == SHIFT) && (r_cnt == c_CNT_LAST);

    always_comb begin
        w_req_ready = '0;
        if (w_accept) begin
            w_req_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)                w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == c_CNT_LAST)     w_state_nxt = DONE;
            DONE:    if (bus.res_ready)           w_state_nxt = IDLE;
            default:                              w_state_nxt = IDLE;
        endcase
    end

    mod_residue_step #(
        .DIVISOR   (DIVISOR)
    ) u_step (
        .i_residue (r_residue),
        .i_bit     (r_shift[WIDTH-1]),
        .o_residue (w_residue_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift      <= '0;
            r_id         <= '0;
            r_residue    <= '0;
            r_cnt        <= '0;
            r_last_grant <= c_ID_LAST;
            r_res_valid  <= 1'b0;
            r_res_div    <= 1'b0;
            r_res_rem    <= '0;
        end else begin
            if (w_accept) begin
                r_shift      <= bus.req_data[w_winner*WIDTH +: WIDTH];
                r_id         <= w_winner;
                r_residue    <= '0;
                r_cnt        <= '0;
                r_last_grant <= w_winner;
            end
            if (r_state == SHIFT) begin
                r_residue <= w_residue_nxt;
                r_shift   <= r_shift << 1;
                r_cnt     <= r_cnt + 1'b1;
            end
            // Result fields are loaded once and held until the consumer takes them.
            if (w_last_bit) begin
                r_res_valid <= 1'b1;
                r_res_rem   <= w_residue_nxt;
                r_res_div   <= (w_residue_nxt == '0);
            end else if ((r_state == DONE) && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_id    = r_id;
    assign bus.res_div   = r_res_div;
    assign bus.res_rem   = r_res_rem;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mod_check_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_check_scheduler
//  Brief    : Vector table plus scoreboard bench for the divisibility scheduler.
//  Revision : 1.0
// ============================================================================
module tb_mod_check_scheduler;
    import mod_check_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int DIV  = 5;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic             div;
        logic [REM_W-1:0] rem;
    } exp_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [W-1:0]    data;
        int              exp_div;
        int              exp_rem;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  drv_valid;
    logic [W-1:0]     drv_data [NREQ];
    logic             drv_res_ready;
    int               cyc = 0;
    int               total = 0;
    int               bad = 0;
    exp_t             sbq [$];

    mod_check_scheduler_if #(.NUM_REQ(NREQ), .WIDTH(W), .DIVISOR(DIV)) bus ();

    mod_check_scheduler #(.NUM_REQ(NREQ), .WIDTH(W), .DIVISOR(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.req_valid = drv_valid;
    assign bus.res_ready = drv_res_ready;
    for (genvar g = 0; g < NREQ; g++) begin : g_data
        assign bus.req_data[g*W +: W] = drv_data[g];
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [ID_W-1:0] oh2id(input logic [NREQ-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = ID_W'(i);
        return r;
    endfunction

    // Scoreboard: expected result pushed at accept, compared at transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            sbq.delete();
        end else begin
            if (bus.req_ready != '0) begin
                e.id  = oh2id(bus.req_ready);
                e.rem = REM_W'(drv_data[e.id] % DIV);
                e.div = ((drv_data[e.id] % DIV) == 0);
                sbq.push_back(e);
            end
            if (bus.res_valid && bus.res_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_spurious_result", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_id",  int'(bus.res_id),  int'(e.id));
                    chk("sb_div", int'(bus.res_div), int'(e.div));
                    chk("sb_rem", int'(bus.res_rem), int'(e.rem));
                end
            end
        end
    end

    task automatic wait_grant(input int maxc, output logic [ID_W-1:0] gid, output bit ok);
        ok  = 1'b0;
        gid = '0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                ok  = 1'b1;
                gid = oh2id(bus.req_ready);
                break;
            end
        end
    endtask

    task automatic wait_resv(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        vec_t            vec [7];
        logic [ID_W-1:0] gid;
        bit              ok;
        int              t0;
        int              prev;
        int              seen3;
        int              nres;

        vec[0] = '{2'd2, 8'd25,  1, 0};
        vec[1] = '{2'd0, 8'd255, 1, 0};
        vec[2] = '{2'd1, 8'd7,   0, 2};
        vec[3] = '{2'd3, 8'd0,   1, 0};
        vec[4] = '{2'd2, 8'd254, 0, 4};
        vec[5] = '{2'd1, 8'd13,  0, 3};
        vec[6] = '{2'd0, 8'd1,   0, 1};

        reset         = 1'b0;
        drv_valid     = '1;
        drv_res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) drv_data[i] = '0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_res_id",    int'(bus.res_id),    0);
        chk("rst_res_div",   int'(bus.res_div),   0);
        chk("rst_res_rem",   int'(bus.res_rem),   0);
        chk("rst_busy",      int'(bus.busy),      0);

        @(posedge clk); #1;
        drv_valid = '0;
        reset     = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            drv_data[vec[i].id] = vec[i].data;
            drv_valid = NREQ'(1 << vec[i].id);
            wait_grant(30, gid, ok);
            chk("tbl_grant_seen", int'(ok), 1);
            chk("tbl_grant_id", int'(gid), int'(vec[i].id));
            t0 = cyc;
            @(posedge clk); #1;
            drv_valid = '0;
            wait_resv(30, ok);
            chk("tbl_res_seen", int'(ok), 1);
            chk("tbl_latency", cyc - t0, 9);
            chk("tbl_res_id",  int'(bus.res_id),  int'(vec[i].id));
            chk("tbl_res_div", int'(bus.res_div), vec[i].exp_div);
            chk("tbl_res_rem", int'(bus.res_rem), vec[i].exp_rem);
        end

        // Reset four cycles into a word from requester 1.
        @(posedge clk); #1;
        drv_data[1] = 8'd123;
        drv_valid   = 4'b0010;
        wait_grant(30, gid, ok);
        chk("rst_mid_grant", int'(gid), 1);
        @(posedge clk); #1;
        drv_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) drv_data[i] = W'(40 + i);
        drv_valid = '1;
        reset     = 1'b0;
        #1;
        chk("rst_mid_req_ready", int'(bus.req_ready), 0);
        chk("rst_mid_res_valid", int'(bus.res_valid), 0);
        chk("rst_mid_res_id",    int'(bus.res_id),    0);
        chk("rst_mid_res_rem",   int'(bus.res_rem),   0);
        chk("rst_mid_busy",      int'(bus.busy),      0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Fairness: all requesting, expect 0,1,2,3,0 ten cycles apart.
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant(30, gid, ok);
            chk("rr_grant_seen", int'(ok), 1);
            chk("rr_onehot", $countones(bus.req_ready), 1);
            chk("rr_grant_id", int'(gid), g % NREQ);
            if (g > 0) chk("rr_interval", cyc - prev, 10);
            prev = cyc;
        end
        @(posedge clk); #1;
        drv_valid = '0;
        wait_resv(30, ok);
        chk("rr_last_res_seen", int'(ok), 1);
        @(posedge clk); #1;

        // Backpressure with another requester waiting.
        drv_data[2] = 8'd200;
        drv_valid   = 4'b0100;
        wait_grant(30, gid, ok);
        chk("bp_grant_id", int'(gid), 2);
        @(posedge clk); #1;
        drv_valid     = '0;
        drv_res_ready = 1'b0;
        wait_resv(30, ok);
        chk("bp_res_seen", int'(ok), 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drv_data[0] = 8'd33;
            drv_valid   = 4'b0001;
            @(negedge clk);
            chk("bp_hold_valid", int'(bus.res_valid), 1);
            chk("bp_hold_id",    int'(bus.res_id),    2);
            chk("bp_hold_div",   int'(bus.res_div),   1);
            chk("bp_hold_rem",   int'(bus.res_rem),   0);
            chk("bp_hold_busy",  int'(bus.busy),      1);
            chk("bp_no_grant",   int'(bus.req_ready), 0);
        end
        @(posedge clk); #1;
        drv_res_ready = 1'b1;
        @(negedge clk);
        chk("bp_xfer_valid", int'(bus.res_valid), 1);
        chk("bp_xfer_no_grant", int'(bus.req_ready), 0);
        @(negedge clk);
        chk("bp_next_grant", int'(bus.req_ready), 1);
        chk("bp_next_res_valid", int'(bus.res_valid), 0);
        @(posedge clk); #1;
        drv_valid = '0;
        wait_resv(30, ok);
        chk("bp_second_res_seen", int'(ok), 1);
        @(posedge clk); #1;

        // Requester 3 pulses valid for one busy cycle and must be skipped.
        drv_data[1] = 8'd9;
        drv_valid   = 4'b0010;
        wait_grant(30, gid, ok);
        chk("drop_grant_id", int'(gid), 1);
        @(posedge clk); #1;
        drv_data[3] = 8'd77;
        drv_valid   = 4'b1000;
        @(posedge clk); #1;
        drv_valid = '0;
        seen3 = 0;
        nres  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.req_ready[3]) seen3++;
            if (bus.res_valid && bus.res_ready) nres++;
        end
        chk("drop_req3_grants", seen3, 0);
        chk("drop_result_count", nres, 1);
        chk("drop_busy_end", int'(bus.busy), 0);
        chk("sb_queue_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
